// File: rtl/prog_loader.sv
// Serial program loader: shifts DEPTH bytes in from two board pins, writes them
// into the program RAM, then reads the RAM back and compares checksums.
module prog_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ser_clk,
  input  logic          ser_data,
  input  logic          load_start,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] r_data,
  output logic          prog_mode,
  output logic [AW-1:0] prog_addr,
  output logic [DW-1:0] w_data,
  output logic [AW-1:0] ram_addr,
  output logic          halt_cpu,
  output logic          busy,
  output logic          done,
  output logic          ok
);

  localparam int BW = $clog2(DW + 1);
  localparam int VW = AW + 1;

  typedef enum logic [2:0] {IDLE, RECV, WRITE, VERIFY, DONE} state_t;

  state_t        state, state_next;
  logic          sclk_s1, sclk_s2, sclk_prev;
  logic          sdat_s1, sdat_s2;
  logic          lst_s1, lst_s2, lst_prev;
  logic          sclk_rise, lst_rise;
  logic [DW-2:0] shreg;
  logic [BW-1:0] bitcnt;
  logic [AW-1:0] addr;
  logic [VW-1:0] vaddr;
  logic [DW-1:0] wsum, rsum, rsum_next;

  // NOTE: every flop uses non-blocking assignment and the asynchronous reset, so
  // order within a block never matters and an abort takes effect without a clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      sdat_s1   <= 1'b0;
      sdat_s2   <= 1'b0;
      lst_s1    <= 1'b0;
      lst_s2    <= 1'b0;
      lst_prev  <= 1'b0;
    end else begin
      sclk_s1   <= ser_clk;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      sdat_s1   <= ser_data;
      sdat_s2   <= sdat_s1;
      lst_s1    <= load_start;
      lst_s2    <= lst_s1;
      lst_prev  <= lst_s2;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_prev;
  assign lst_rise  = lst_s2 & ~lst_prev;
  assign rsum_next = rsum + r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: all outputs of this block get a default first, so no latch can be inferred.
  always_comb begin
    state_next = state;
    prog_mode  = 1'b0;
    busy       = 1'b0;
    ram_addr   = cpu_addr;
    case (state)
      IDLE, DONE: if (lst_rise) state_next = RECV;
      RECV: begin
        busy = 1'b1;
        if (sclk_rise && bitcnt == BW'(DW - 1)) state_next = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        prog_mode  = 1'b1;
        state_next = (addr == AW'(DEPTH - 1)) ? VERIFY : RECV;
      end
      VERIFY: begin
        busy     = 1'b1;
        ram_addr = vaddr[AW-1:0];
        if (vaddr == VW'(DEPTH)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign halt_cpu = busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      bitcnt    <= '0;
      addr      <= '0;
      vaddr     <= '0;
      wsum      <= '0;
      rsum      <= '0;
      prog_addr <= '0;
      w_data    <= '0;
      done      <= 1'b0;
      ok        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (lst_rise) begin
            addr   <= '0;
            bitcnt <= '0;
            wsum   <= '0;
            rsum   <= '0;
            done   <= 1'b0;
            ok     <= 1'b0;
          end
        end
        RECV: begin
          if (sclk_rise) begin
            shreg <= {shreg[DW-3:0], sdat_s2};
            if (bitcnt == BW'(DW - 1)) begin
              bitcnt    <= '0;
              w_data    <= {shreg, sdat_s2};
              prog_addr <= addr;
            end else begin
              bitcnt <= bitcnt + BW'(1);
            end
          end
        end
        WRITE: begin
          wsum <= wsum + w_data;
          if (addr == AW'(DEPTH - 1)) vaddr <= '0;
          else                        addr  <= addr + AW'(1);
        end
        VERIFY: begin
          vaddr <= vaddr + VW'(1);
          // Read data lags the address by one clk, so cycle 0 has nothing to add.
          if (vaddr != '0) rsum <= rsum_next;
          if (vaddr == VW'(DEPTH)) begin
            done <= 1'b1;
            ok   <= (rsum_next == wsum);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
